decode_stage: RTL

- Instruction-decode stage directly downstream of the fetch unit (prog_counter + instr_mem).
- Registers each fetched {pc, instr} pair into an IF/ID register and splits the 9-bit instruction into fields.
- Resolves JMP/BRZ and drives the branch, taken and target inputs of prog_counter, squashing the one wrong-path fetch after a taken branch.
- Detects HALT, raises done, and counts decoded instructions.

---
 rtl/decode_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID register, field split, JMP/BRZ resolution
// feeding prog_counter, HALT detection and a saturating decoded-instruction count.
module decode_stage #(
    parameter int width     = 9,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 zero_flag,
    input  logic [width-1:0]     pc_in,
    input  logic [width-1:0]     instr_in,
    output logic                 id_valid,
    output logic [width-1:0]     id_pc,
    output logic [width-1:0]     id_instr,
    output logic [2:0]           opcode,
    output logic [2:0]           rd,
    output logic [2:0]           rs,
    output logic                 branch,
    output logic                 taken,
    output logic [width-1:0]     target,
    output logic                 done,
    output logic [cnt_width-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_BRZ = 3'b111;

    state_t               state_reg;
    logic                 id_valid_reg;
    logic [width-1:0]     id_pc_reg;
    logic [width-1:0]     id_instr_reg;
    logic                 done_reg;
    logic [cnt_width-1:0] instr_count_reg;

    logic                 resolve;
    logic [width-1:0]     brz_offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            id_valid_reg    <= 1'b0;
            id_pc_reg       <= '0;
            id_instr_reg    <= '0;
            done_reg        <= 1'b0;
            instr_count_reg <= '0;
        end else if (start) begin
            // start wins over everything, including a taken branch in ID
            state_reg       <= RUN;
            id_valid_reg    <= 1'b0;
            done_reg        <= 1'b0;
            instr_count_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (id_valid_reg && (instr_count_reg != {cnt_width{1'b1}}))
                        instr_count_reg <= instr_count_reg + cnt_width'(1);
                    if (taken) begin
                        id_valid_reg <= 1'b0;
                    end else if (id_valid_reg && (id_instr_reg == '0)) begin
                        state_reg    <= HALT;
                        id_valid_reg <= 1'b0;
                        done_reg     <= 1'b1;
                    end else begin
                        id_pc_reg    <= pc_in;
                        id_instr_reg <= instr_in;
                        id_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and HALT only leave on start
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign id_valid    = id_valid_reg;
    assign id_pc       = id_pc_reg;
    assign id_instr    = id_instr_reg;
    assign done        = done_reg;
    assign instr_count = instr_count_reg;

    assign opcode = id_instr_reg[8:6];
    assign rd     = id_instr_reg[5:3];
    assign rs     = id_instr_reg[2:0];

    assign resolve    = id_valid_reg && (state_reg == RUN);
    assign brz_offset = {{(width-6){id_instr_reg[5]}}, id_instr_reg[5:0]};

    always_comb begin
        branch = 1'b0;
        taken  = 1'b0;
        target = '0;
        case (opcode)
            OP_JMP: begin
                branch = resolve;
                taken  = resolve;
                target = width'({id_instr_reg[5:0], 3'b000});
            end
            OP_BRZ: begin
                branch = resolve;
                taken  = resolve & zero_flag;
                target = id_pc_reg + brz_offset;
            end
            default: begin
                branch = 1'b0;
                taken  = 1'b0;
                target = '0;
            end
        endcase
    end

endmodule
